operand_stage: RTL and testbench
================================

OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/data width in bits.
REQ-002 SHALL have parameter RIDX_W, default 5, meaning register-index width.
REQ-003 SHALL have parameter SEL_W, default 2, meaning operand-select code width (4 sources).
REQ-004 SHALL have port CLK  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port IN_VALID  in  1  upstream offers an operand request.
REQ-007 SHALL have port IN_READY  out  1  stage can accept a request this cycle.
REQ-008 SHALL have ports IMM, INST, PC, RD1, RD2  in  WIDTH each  candidate operand sources.
REQ-009 SHALL have ports RS1_IDX, RS2_IDX  in  RIDX_W each  register indices behind RD1/RD2.
REQ-010 SHALL have ports CTL1, CTL2  in  SEL_W each  operand-1/operand-2 source select.
REQ-011 SHALL have ports WB_EN  in  1, WB_IDX  in  RIDX_W, WB_DATA  in  WIDTH  writeback bypass.
REQ-012 SHALL have port OUT_VALID  out  1  OP1/OP2 hold a valid pair.
REQ-013 SHALL have port OUT_READY  in  1  downstream consumes the pair this cycle.
REQ-014 SHALL have ports OP1, OP2  out  WIDTH each  selected operands.

Function
REQ-015 CTL1 codes SHALL select: OP1_SRC_IMM->IMM, OP1_SRC_INST->INST, OP1_SRC_RD->RD1, OP1_SRC_PC->PC.
REQ-016 CTL2 codes SHALL select: OP2_SRC_IMM->IMM, OP2_SRC_INST->INST, OP2_SRC_RD->RD2, OP2_SRC_ZERO->0.
REQ-017 Bypass at accept: if source is RD, WB_EN=1, WB_IDX==RSx_IDX and RSx_IDX!=0, captured value SHALL be WB_DATA instead of RDx.
REQ-018 Index 0 SHALL never be bypassed; RDx passes unchanged.
REQ-019 A request SHALL be accepted when IN_VALID and IN_READY are both 1; a pair SHALL be consumed when OUT_VALID and OUT_READY are both 1.
REQ-020 Buffering SHALL be a 2-entry skid: output register plus one skid register; latency accept->OUT_VALID is 1 cycle.
REQ-021 IN_READY SHALL be registered and equal 1 exactly when the skid entry is empty.
REQ-022 States: EMPTY (no entry), ONE (output valid, skid empty), FULL (both valid).
REQ-023 EMPTY->ONE on accept; ONE->EMPTY on consume without accept; ONE stays ONE on simultaneous accept+consume (new pair loads output); ONE->FULL on accept without consume; FULL->ONE on consume (skid moves to output); no accept in FULL.
REQ-024 Order SHALL be strictly FIFO; no pair dropped or duplicated.
REQ-025 Each held entry SHALL store per operand a reg-source flag and index; while held, a matching writeback (REQ-017 rules) SHALL overwrite that operand in the same cycle, output and skid alike.
REQ-026 OP1/OP2 SHALL be stable while OUT_VALID=1 and OUT_READY=0, except for REQ-025 updates.
REQ-027 Writeback and accept in the same cycle SHALL both apply: the new entry captures WB_DATA per REQ-017, held entries update per REQ-025.
REQ-028 Result width SHALL be WIDTH throughout; no extension or truncation.

Reset
REQ-029 On RST=1 at a clock edge: state EMPTY, OUT_VALID=0, IN_READY=1, OP1=0, OP2=0, all flags cleared.
REQ-030 RST SHALL override a simultaneous accept, consume or writeback; in-flight pairs are discarded.

Structure
REQ-031 Select codes OP1_SRC_*/OP2_SRC_* SHALL live in the shared defs.v, extending the existing OP1 encodings.
REQ-032 One combinational sub-module operand_sel (select + bypass for one operand) SHALL be instantiated twice.
REQ-033 No latches; all sequential logic in one clocked process per register group.

Verification
REQ-034 CTL1=IMM, IMM=0x12345678, IN_VALID=1, OUT_READY=1 -> next cycle OUT_VALID=1, OP1=0x12345678.
REQ-035 CTL1=RD, RS1_IDX=3, RD1=0x1, WB_EN=1, WB_IDX=3, WB_DATA=0xAA -> OP1=0xAA; same with RS1_IDX=0 -> OP1=0x1.
REQ-036 OUT_READY=0, three back-to-back requests A,B,C -> A,B held, IN_READY=0 after B, C waits; OUT_READY=1 -> A,B,C in order.
REQ-037 Pair held with CTL2=RD, RS2_IDX=7; WB_EN=1, WB_IDX=7, WB_DATA=0x55 during stall -> OP2 becomes 0x55 next cycle.
REQ-038 RST asserted in FULL -> next cycle OUT_VALID=0, IN_READY=1, OP1=OP2=0.
REQ-039 CTL2=ZERO with IMM=0xFFFFFFFF -> OP2=0.

Source files
------------

// File: rtl/operand_stage_pkg.sv
// ---------------------------------------------------------------------------
// operand_stage_pkg : shared select codes and state encoding   (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package operand_stage_pkg;

  // Raw source slots; OP1 and OP2 share slots 0-2 and differ only in slot 3.
  localparam logic [1:0] SRC_CODE_IMM  = 2'd0;
  localparam logic [1:0] SRC_CODE_INST = 2'd1;
  localparam logic [1:0] SRC_CODE_RD   = 2'd2;
  localparam logic [1:0] SRC_CODE_ALT  = 2'd3;

  typedef enum logic [1:0] {
    OP1_SRC_IMM  = SRC_CODE_IMM,
    OP1_SRC_INST = SRC_CODE_INST,
    OP1_SRC_RD   = SRC_CODE_RD,
    OP1_SRC_PC   = SRC_CODE_ALT
  } op1_src_e;

  typedef enum logic [1:0] {
    OP2_SRC_IMM  = SRC_CODE_IMM,
    OP2_SRC_INST = SRC_CODE_INST,
    OP2_SRC_RD   = SRC_CODE_RD,
    OP2_SRC_ZERO = SRC_CODE_ALT
  } op2_src_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/operand_stage_sel.sv
// ---------------------------------------------------------------------------
// operand_sel : one-operand source mux with writeback bypass     (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module operand_sel
  import operand_stage_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int RIDX_W = 5,
  parameter int SEL_W  = 2
) (
  input  logic [SEL_W-1:0]  sel,
  input  logic [WIDTH-1:0]  src_imm,
  input  logic [WIDTH-1:0]  src_inst,
  input  logic [WIDTH-1:0]  src_rd,
  input  logic [WIDTH-1:0]  src_alt,
  input  logic [RIDX_W-1:0] rs_idx,
  input  logic              wb_en,
  input  logic [RIDX_W-1:0] wb_idx,
  input  logic [WIDTH-1:0]  wb_data,
  output logic [WIDTH-1:0]  value,
  output logic              is_reg
);

  always_comb begin
    value  = '0;
    is_reg = (sel == SEL_W'(SRC_CODE_RD));
    case (sel)
      SEL_W'(SRC_CODE_IMM):  value = src_imm;
      SEL_W'(SRC_CODE_INST): value = src_inst;
      SEL_W'(SRC_CODE_RD):   value = src_rd;
      SEL_W'(SRC_CODE_ALT):  value = src_alt;
      default:               value = '0;
    endcase
    // Register 0 is hardwired, so a writeback to it is never forwarded.
    if (is_reg && wb_en && (wb_idx == rs_idx) && (rs_idx != '0))
      value = wb_data;
  end

endmodule

`default_nettype wire

// File: rtl/operand_stage.sv
// ---------------------------------------------------------------------------
// operand_stage : operand select + bypass behind a 2-entry skid buffer (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module operand_stage
  import operand_stage_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int RIDX_W = 5,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  imm,
  input  logic [WIDTH-1:0]  inst,
  input  logic [WIDTH-1:0]  pc,
  input  logic [WIDTH-1:0]  rd1,
  input  logic [WIDTH-1:0]  rd2,
  input  logic [RIDX_W-1:0] rs1_idx,
  input  logic [RIDX_W-1:0] rs2_idx,
  input  logic [SEL_W-1:0]  ctl1,
  input  logic [SEL_W-1:0]  ctl2,
  input  logic              wb_en,
  input  logic [RIDX_W-1:0] wb_idx,
  input  logic [WIDTH-1:0]  wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  op1,
  output logic [WIDTH-1:0]  op2
);

  state_e             state;
  logic [WIDTH-1:0]   new_op1, new_op2;
  logic               new_reg1, new_reg2;
  logic [WIDTH-1:0]   out_op1, out_op2, skid_op1, skid_op2;
  logic               out_reg1, out_reg2, skid_reg1, skid_reg2;
  logic [RIDX_W-1:0]  out_idx1, out_idx2, skid_idx1, skid_idx2;
  logic [WIDTH-1:0]   out_op1_p, out_op2_p, skid_op1_p, skid_op2_p;
  logic               accept, consume;

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;
  assign op1     = out_op1;
  assign op2     = out_op2;

  operand_sel #(.WIDTH(WIDTH), .RIDX_W(RIDX_W), .SEL_W(SEL_W)) u_sel1 (
    .sel(ctl1), .src_imm(imm), .src_inst(inst), .src_rd(rd1), .src_alt(pc),
    .rs_idx(rs1_idx), .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data),
    .value(new_op1), .is_reg(new_reg1)
  );

  operand_sel #(.WIDTH(WIDTH), .RIDX_W(RIDX_W), .SEL_W(SEL_W)) u_sel2 (
    .sel(ctl2), .src_imm(imm), .src_inst(inst), .src_rd(rd2), .src_alt('0),
    .rs_idx(rs2_idx), .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data),
    .value(new_op2), .is_reg(new_reg2)
  );

  function automatic logic [WIDTH-1:0] patch(
    input logic [WIDTH-1:0]  val,
    input logic              is_reg,
    input logic [RIDX_W-1:0] idx,
    input logic              en,
    input logic [RIDX_W-1:0] widx,
    input logic [WIDTH-1:0]  wdata
  );
    patch = (is_reg && en && (widx == idx) && (idx != '0)) ? wdata : val;
  endfunction

  // Held operands track register writebacks for as long as they wait.
  assign out_op1_p  = patch(out_op1,  out_reg1,  out_idx1,  wb_en, wb_idx, wb_data);
  assign out_op2_p  = patch(out_op2,  out_reg2,  out_idx2,  wb_en, wb_idx, wb_data);
  assign skid_op1_p = patch(skid_op1, skid_reg1, skid_idx1, wb_en, wb_idx, wb_data);
  assign skid_op2_p = patch(skid_op2, skid_reg2, skid_idx2, wb_en, wb_idx, wb_data);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: if (accept) begin
          state     <= ST_ONE;
          out_valid <= 1'b1;
        end
        ST_ONE: begin
          if (accept && !consume) begin
            state    <= ST_FULL;
            in_ready <= 1'b0;
          end else if (consume && !accept) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
          end
        end
        ST_FULL: if (consume) begin
          state    <= ST_ONE;
          in_ready <= 1'b1;
        end
        default: begin
          state     <= ST_EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_op1  <= '0;  out_op2  <= '0;
      out_reg1 <= 1'b0; out_reg2 <= 1'b0;
      out_idx1 <= '0;  out_idx2 <= '0;
      skid_op1 <= '0;  skid_op2 <= '0;
      skid_reg1 <= 1'b0; skid_reg2 <= 1'b0;
      skid_idx1 <= '0; skid_idx2 <= '0;
    end else begin
      out_op1  <= out_op1_p;
      out_op2  <= out_op2_p;
      skid_op1 <= skid_op1_p;
      skid_op2 <= skid_op2_p;
      if (accept && (state == ST_EMPTY || consume)) begin
        out_op1  <= new_op1;  out_op2  <= new_op2;
        out_reg1 <= new_reg1; out_reg2 <= new_reg2;
        out_idx1 <= rs1_idx;  out_idx2 <= rs2_idx;
      end else if (accept) begin
        skid_op1  <= new_op1;  skid_op2  <= new_op2;
        skid_reg1 <= new_reg1; skid_reg2 <= new_reg2;
        skid_idx1 <= rs1_idx;  skid_idx2 <= rs2_idx;
      end else if (state == ST_FULL && consume) begin
        out_op1  <= skid_op1_p; out_op2  <= skid_op2_p;
        out_reg1 <= skid_reg1;  out_reg2 <= skid_reg2;
        out_idx1 <= skid_idx1;  out_idx2 <= skid_idx2;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_operand_stage : directed self-checking bench for operand_stage (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_operand_stage;
  import operand_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] imm, inst, pc, rd1, rd2, wb_data, op1, op2;
  logic [4:0]  rs1_idx, rs2_idx, wb_idx;
  logic [1:0]  ctl1, ctl2;
  logic        wb_en;
  int          checks = 0;
  int          passes = 0;

  operand_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .imm(imm), .inst(inst), .pc(pc), .rd1(rd1), .rd2(rd2),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .ctl1(ctl1), .ctl2(ctl2),
    .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .op1(op1), .op2(op2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    imm = '0; inst = '0; pc = '0; rd1 = '0; rd2 = '0;
    rs1_idx = '0; rs2_idx = '0; ctl1 = OP1_SRC_IMM; ctl2 = OP2_SRC_IMM;
    wb_en = 1'b0; wb_idx = '0; wb_data = '0;
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_op1", op1, 32'h0);
    check("rst_op2", op2, 32'h0);
    rst = 1'b0;

    // Basic selection, one cycle latency
    in_valid = 1'b1; ctl1 = OP1_SRC_IMM; ctl2 = OP2_SRC_ZERO; imm = 32'h12345678;
    tick();
    check("imm_valid", 32'(out_valid), 32'd1);
    check("imm_op1", op1, 32'h12345678);
    check("imm_in_ready", 32'(in_ready), 32'd1);
    ctl1 = OP1_SRC_PC; pc = 32'h0000_1000; ctl2 = OP2_SRC_ZERO; imm = 32'hFFFFFFFF;
    tick();
    check("pc_op1", op1, 32'h0000_1000);
    check("zero_op2", op2, 32'h0);
    ctl1 = OP1_SRC_INST; inst = 32'hDEADBEEF; ctl2 = OP2_SRC_IMM; imm = 32'hCAFEF00D;
    tick();
    check("inst_op1", op1, 32'hDEADBEEF);
    check("imm_op2", op2, 32'hCAFEF00D);

    // Bypass at accept, and index 0 never bypassed
    ctl1 = OP1_SRC_RD; rs1_idx = 5'd3; rd1 = 32'h1;
    ctl2 = OP2_SRC_RD; rs2_idx = 5'd5; rd2 = 32'h22;
    wb_en = 1'b1; wb_idx = 5'd3; wb_data = 32'hAA;
    tick();
    check("byp_op1", op1, 32'hAA);
    check("nobyp_op2", op2, 32'h22);
    rs1_idx = 5'd0; wb_idx = 5'd0;
    tick();
    check("idx0_op1", op1, 32'h1);
    in_valid = 1'b0; wb_en = 1'b0;
    tick();
    check("drain_valid", 32'(out_valid), 32'd0);

    // Stall: A,B held, C waits, then FIFO drain
    out_ready = 1'b0; in_valid = 1'b1; ctl1 = OP1_SRC_IMM; ctl2 = OP2_SRC_ZERO;
    imm = 32'hA1;
    tick();
    check("A_op1", op1, 32'hA1);
    check("A_in_ready", 32'(in_ready), 32'd1);
    imm = 32'hB2;
    tick();
    check("B_in_ready", 32'(in_ready), 32'd0);
    check("B_op1_stable", op1, 32'hA1);
    imm = 32'hC3;
    tick();
    check("C_wait_in_ready", 32'(in_ready), 32'd0);
    check("C_wait_op1", op1, 32'hA1);
    out_ready = 1'b1;
    tick();
    check("fifo_B", op1, 32'hB2);
    check("fifo_B_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("fifo_C", op1, 32'hC3);
    check("fifo_C_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();
    check("fifo_empty", 32'(out_valid), 32'd0);

    // Writeback updates held output and skid entries
    out_ready = 1'b0; in_valid = 1'b1;
    ctl1 = OP1_SRC_IMM; imm = 32'h0; rs1_idx = 5'd4;
    ctl2 = OP2_SRC_RD; rs2_idx = 5'd7; rd2 = 32'h11;
    tick();
    check("held_op2", op2, 32'h11);
    in_valid = 1'b0; wb_en = 1'b1; wb_idx = 5'd7; wb_data = 32'h55;
    tick();
    check("wb_held_op2", op2, 32'h55);
    wb_en = 1'b0; in_valid = 1'b1;
    ctl1 = OP1_SRC_RD; rs1_idx = 5'd4; rd1 = 32'h33; ctl2 = OP2_SRC_ZERO;
    tick();
    check("skid_full", 32'(in_ready), 32'd0);
    in_valid = 1'b0; wb_en = 1'b1; wb_idx = 5'd4; wb_data = 32'h44;
    tick();
    check("wb_imm_untouched", op1, 32'h0);
    check("wb_out_op2_kept", op2, 32'h55);
    wb_en = 1'b0; out_ready = 1'b1;
    tick();
    check("wb_skid_op1", op1, 32'h44);
    check("wb_skid_op2", op2, 32'h0);
    tick();
    check("wb_drain", 32'(out_valid), 32'd0);

    // Reset while full
    out_ready = 1'b0; in_valid = 1'b1; ctl1 = OP1_SRC_IMM; ctl2 = OP2_SRC_IMM;
    imm = 32'h77;
    tick(); tick();
    check("full_before_rst", 32'(in_ready), 32'd0);
    rst = 1'b1;
    tick();
    check("rstfull_out_valid", 32'(out_valid), 32'd0);
    check("rstfull_in_ready",  32'(in_ready),  32'd1);
    check("rstfull_op1", op1, 32'h0);
    check("rstfull_op2", op2, 32'h0);
    rst = 1'b0; in_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
